// File: rtl/wb_sram_pkg.sv
// -----------------------------------------------------------------------------
// wb_sram_pkg
// Shared types and constants for the Wishbone-to-SRAM bank controller.
//   state_e           : controller FSM states
//   WB_SRAM_BASE_ADDR : default byte base of the SRAM window
//   calc_bank_w()     : bank-index width, 0 for a single bank
// -----------------------------------------------------------------------------
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam logic [31:0] WB_SRAM_BASE_ADDR = 32'h3000_0000;

    function automatic int calc_bank_w(input int num_banks);
        if (num_banks <= 1) begin
            return 0;
        end else begin
            return $clog2(num_banks);
        end
    endfunction

endpackage

// File: rtl/wb_sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// wb_sram_bank_ctrl
// Wishbone classic slave in front of NUM_BANKS single-port SRAM macros.
// Decodes the byte address into bank/word, issues one registered strobe to
// the addressed macro, waits READ_LAT clocks for read data and returns a
// one-cycle acknowledge. Accesses outside the window ack immediately with
// zero data and raise a sticky error flag.
// Ports:
//   wb_clk_i / wb_rst_ni       : clock, asynchronous active-low reset
//   wbs_*                      : Wishbone slave (cyc, stb, we, sel, adr, dat, ack)
//   sram_csb_o                 : per-bank chip select, active low
//   sram_web_o / sram_wmask_o  : shared write enable (low) and byte mask
//   sram_addr_o / sram_din_o   : shared word address and write data
//   sram_dout_i                : concatenated read data, bank b at [b*DATA_W +: DATA_W]
//   err_clr_i / err_o          : sticky out-of-range flag and its clear
// -----------------------------------------------------------------------------
module wb_sram_bank_ctrl
    import wb_sram_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          SEL_W     = DATA_W / 8,
    parameter int          ADDR_W    = 8,
    parameter int          NUM_BANKS = 2,
    parameter int          BANK_W    = calc_bank_w(NUM_BANKS),
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = WB_SRAM_BASE_ADDR
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [SEL_W-1:0]            wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [DATA_W-1:0]           wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [DATA_W-1:0]           wbs_dat_o,
    output logic [NUM_BANKS-1:0]        sram_csb_o,
    output logic                        sram_web_o,
    output logic [SEL_W-1:0]            sram_wmask_o,
    output logic [ADDR_W-1:0]           sram_addr_o,
    output logic [DATA_W-1:0]           sram_din_o,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_dout_i,
    input  logic                        err_clr_i,
    output logic                        err_o
);

    // A single bank still needs a 1-bit index vector; it is simply tied to 0.
    localparam int BANK_IW = (BANK_W == 0) ? 1 : BANK_W;
    localparam int TAG_LSB = 2 + ADDR_W + BANK_W;
    localparam int CNT_W   = 2;

    state_e                r_state;
    logic                  r_we;
    logic [BANK_IW-1:0]    r_bank;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ack;
    logic [DATA_W-1:0]     r_dat;
    logic [NUM_BANKS-1:0]  r_csb;
    logic                  r_web;
    logic [SEL_W-1:0]      r_wmask;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_din;
    logic                  r_err;

    logic                  w_req;
    logic                  w_in_range;
    logic                  w_err_set;
    logic [ADDR_W-1:0]     w_word;
    logic [BANK_IW-1:0]    w_bank;
    logic [NUM_BANKS-1:0]  w_csb_sel;
    logic [DATA_W-1:0]     w_dout_bank [NUM_BANKS];
    logic [DATA_W-1:0]     w_dout_sel;
    logic                  w_unused;

    assign w_req      = wbs_cyc_i & wbs_stb_i;
    assign w_in_range = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign w_word     = wbs_adr_i[2 +: ADDR_W];
    assign w_err_set  = (r_state == ST_IDLE) & w_req & ~w_in_range;
    // Byte offset within a word is irrelevant for word-wide macros.
    assign w_unused   = ^{wbs_adr_i[1:0]};

    generate
        if (BANK_W == 0) begin : g_one_bank
            assign w_bank = {BANK_IW{1'b0}};
        end else begin : g_multi_bank
            assign w_bank = wbs_adr_i[2 + ADDR_W +: BANK_IW];
        end
    endgenerate

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_dout
        assign w_dout_bank[b] = sram_dout_i[b*DATA_W +: DATA_W];
    end
    assign w_dout_sel = w_dout_bank[r_bank];

    // One-hot-low chip select for the bank addressed by the incoming request
    always_comb begin
        w_csb_sel         = {NUM_BANKS{1'b1}};
        w_csb_sel[w_bank] = 1'b0;
    end

    // Transaction FSM together with the registered bus and macro-side outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_bank  <= {BANK_IW{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_ack   <= 1'b0;
            r_dat   <= {DATA_W{1'b0}};
            r_csb   <= {NUM_BANKS{1'b1}};
            r_web   <= 1'b1;
            r_wmask <= {SEL_W{1'b0}};
            r_addr  <= {ADDR_W{1'b0}};
            r_din   <= {DATA_W{1'b0}};
        end else begin
            // Strobes and ack are single-cycle pulses unless re-armed below.
            r_ack   <= 1'b0;
            r_csb   <= {NUM_BANKS{1'b1}};
            r_web   <= 1'b1;
            r_wmask <= {SEL_W{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_in_range) begin
                        r_we    <= wbs_we_i;
                        r_bank  <= w_bank;
                        r_addr  <= w_word;
                        r_din   <= wbs_dat_i;
                        r_csb   <= w_csb_sel;
                        r_web   <= ~wbs_we_i;
                        r_wmask <= wbs_we_i ? wbs_sel_i : {SEL_W{1'b0}};
                        r_state <= ST_STROBE;
                    end else if (w_req) begin
                        r_dat   <= {DATA_W{1'b0}};
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STROBE: begin
                    if (r_we) begin
                        r_ack   <= w_req;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= CNT_W'(READ_LAT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Data is captured even if the master has abandoned the cycle.
                        r_dat   <= w_dout_sel;
                        r_ack   <= w_req;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky out-of-range flag; a new error outranks a simultaneous clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign sram_csb_o   = r_csb;
    assign sram_web_o   = r_web;
    assign sram_wmask_o = r_wmask;
    assign sram_addr_o  = r_addr;
    assign sram_din_o   = r_din;
    assign err_o        = r_err;

endmodule

// File: tb/tb_wb_sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_bank_ctrl
// Directed plus randomized Wishbone traffic against wb_sram_bank_ctrl with
// READ_LAT = 3. A behavioural macro model returns stored data after the
// programmed latency; expected acks and strobes are queued when a request is
// issued and checked by an independent monitor.
// -----------------------------------------------------------------------------
module tb_wb_sram_bank_ctrl;

    localparam int          NB   = 2;
    localparam int          RL   = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] WIN  = 32'(NB * 256 * 4);

    typedef struct packed {
        int          cyc;
        logic [31:0] dat;
    } ack_t;

    typedef struct packed {
        int          cyc;
        logic [1:0]  csb;
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
    } stb_t;

    logic          clk = 1'b0;
    logic          wb_rst_ni;
    logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic [1:0]    sram_csb_o;
    logic          sram_web_o;
    logic [3:0]    sram_wmask_o;
    logic [7:0]    sram_addr_o;
    logic [31:0]   sram_din_o;
    logic [63:0]   sram_dout_i;
    logic          err_clr_i;
    logic          err_o;

    int            total = 0;
    int            bad = 0;
    int            cyc_cnt = 0;
    int            idle_from = 0;
    logic [31:0]   last_rd = 32'h0;
    logic [31:0]   ref_mem [NB*256];
    ack_t          ack_q[$];
    stb_t          stb_q[$];

    // macro model state
    bit            mac_ready;
    logic [31:0]   mac_mem [NB][256];
    logic [31:0]   mac_dout [NB];
    int            pend [NB];
    logic [31:0]   pend_d [NB];

    wb_sram_bank_ctrl #(
        .DATA_W(32), .ADDR_W(8), .NUM_BANKS(NB), .READ_LAT(RL), .BASE_ADDR(BASE)
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
        .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i),
        .err_clr_i(err_clr_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] init_val(input int idx);
        return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Single-port macro model: write with byte mask, read data valid RL clocks later
    always @(posedge clk) begin
        if (!mac_ready) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < 256; w++)
                    mac_mem[b][w] <= init_val(b*256 + w);
            mac_ready <= 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (!sram_csb_o[b]) begin
                    if (!sram_web_o) begin
                        for (int i = 0; i < 4; i++)
                            if (sram_wmask_o[i])
                                mac_mem[b][sram_addr_o][8*i +: 8] <= sram_din_o[8*i +: 8];
                    end else if (RL == 1) begin
                        mac_dout[b] <= mac_mem[b][sram_addr_o];
                    end else begin
                        mac_dout[b] <= mac_mem[b][sram_addr_o] ^ 32'hDEAD_BEEF;
                        pend[b]     <= RL - 1;
                        pend_d[b]   <= mac_mem[b][sram_addr_o];
                    end
                end else if (pend[b] != 0) begin
                    pend[b] <= pend[b] - 1;
                    if (pend[b] == 1) mac_dout[b] <= pend_d[b];
                end
            end
        end
    end

    always_comb begin
        sram_dout_i = 64'h0;
        for (int b = 0; b < NB; b++) sram_dout_i[b*32 +: 32] = mac_dout[b];
    end

    // Monitor: every ack and every strobe cycle must match the head of its queue
    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1) begin
            if (ack_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got ack=1 want ack=0 (cycle %0d)", cyc_cnt);
            end else begin
                chk("ack_cycle", cyc_cnt, ack_q[0].cyc);
                chk("ack_data", wbs_dat_o, ack_q[0].dat);
                void'(ack_q.pop_front());
            end
        end
        if (sram_csb_o !== 2'b11) begin
            if (stb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stb_unexpected: got csb=%b want 11 (cycle %0d)", sram_csb_o, cyc_cnt);
            end else begin
                chk("stb_cycle", cyc_cnt, stb_q[0].cyc);
                chk("stb_csb", 32'(sram_csb_o), 32'(stb_q[0].csb));
                chk("stb_web", 32'(sram_web_o), 32'(stb_q[0].web));
                chk("stb_wmask", 32'(sram_wmask_o), 32'(stb_q[0].wmask));
                chk("stb_addr", 32'(sram_addr_o), 32'(stb_q[0].addr));
                chk("stb_din", sram_din_o, stb_q[0].din);
                void'(stb_q.pop_front());
            end
        end
    end

    // mode 0: normal; 1: master drops cyc in the first wait cycle; 2: reset during strobe
    task automatic do_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, input int mode);
        int          n, a, idx;
        logic [31:0] off;
        logic        in_rng;
        stb_t        s;
        ack_t        k;
        @(negedge clk);
        while (cyc_cnt + 1 < idle_from) @(negedge clk);
        n = cyc_cnt + 1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
        off    = adr - BASE;
        in_rng = (off < WIN);
        if (!in_rng) begin
            a       = n;
            last_rd = 32'h0;
        end else begin
            idx     = int'(off >> 2);
            s.cyc   = n;
            s.csb   = 2'b11 & ~(2'b01 << (idx / 256));
            s.web   = ~we;
            s.wmask = we ? sel : 4'h0;
            s.addr  = 8'(idx % 256);
            s.din   = dat;
            stb_q.push_back(s);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (sel[i]) ref_mem[idx][8*i +: 8] = dat[8*i +: 8];
                a = n + 1;
            end else begin
                last_rd = ref_mem[idx];
                a = n + 1 + RL;
            end
        end
        idle_from = a + 2;
        if (mode == 0) begin
            k.cyc = a;
            k.dat = last_rd;
            ack_q.push_back(k);
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (wbs_ack_o === 1'b1) break;
            end
            if (wbs_ack_o !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL ack_timeout: got no ack want ack by cycle %0d", a);
            end
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            if (!in_rng) begin
                chk("err_set", 32'(err_o), 32'h1);
                err_clr_i = 1'b1;
                @(negedge clk);
                err_clr_i = 1'b0;
                chk("err_clr", 32'(err_o), 32'h0);
            end
        end else if (mode == 1) begin
            @(negedge clk);
            @(negedge clk);
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end else begin
            @(negedge clk);
            #2;
            wb_rst_ni = 1'b0;
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            #1;
            chk("rst_mid_csb", 32'(sram_csb_o), 32'h3);
            chk("rst_mid_ack", 32'(wbs_ack_o), 32'h0);
            chk("rst_mid_dat", wbs_dat_o, 32'h0);
            @(negedge clk);
            wb_rst_ni = 1'b1;
            last_rd   = 32'h0;
            idle_from = cyc_cnt + 1;
        end
    endtask

    initial begin
        logic [31:0] adr;
        int          r, mode;
        logic        we;
        for (int i = 0; i < NB*256; i++) ref_mem[i] = init_val(i);
        wb_rst_ni = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        err_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_csb", 32'(sram_csb_o), 32'h3);
        chk("rst_web", 32'(sram_web_o), 32'h1);
        chk("rst_wmask", 32'(sram_wmask_o), 32'h0);
        chk("rst_addr", 32'(sram_addr_o), 32'h0);
        chk("rst_din", sram_din_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        wb_rst_ni = 1'b1;

        do_txn(32'h3000_0010, 1'b1, 4'hF, 32'hA5A5_1234, 0);
        do_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0BAD_0001, 0);
        do_txn(32'h3000_0404, 1'b1, 4'hF, 32'h1122_3344, 0);
        do_txn(32'h3000_0404, 1'b1, 4'b0010, 32'h0000_FF00, 0);
        do_txn(32'h3000_0404, 1'b0, 4'h0, 32'h0, 0);
        do_txn(32'h3000_0010, 1'b1, 4'h0, 32'hFFFF_FFFF, 0);
        do_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0);
        do_txn(32'h3001_0000, 1'b0, 4'hF, 32'h0, 0);
        // error set coinciding with a clear request
        err_clr_i = 1'b1;
        do_txn(32'h2000_0000, 1'b1, 4'hF, 32'h1234_5678, 0);
        do_txn(32'h3000_0407, 1'b0, 4'hF, 32'h0, 0);
        do_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 1);
        do_txn(32'h3000_0008, 1'b1, 4'hF, 32'h7777_8888, 0);
        do_txn(32'h3000_0404, 1'b0, 4'hF, 32'h0, 2);
        do_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0);

        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                adr = $urandom;
                if ((adr - BASE) < WIN) adr = adr ^ 32'h0010_0000;
            end else if (r < 6) begin
                adr = BASE + 32'($urandom_range(0, 1)) * 32'd1024
                           + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
            end else begin
                adr = BASE + 32'($urandom_range(0, WIN - 1));
            end
            we   = 1'($urandom_range(0, 1));
            mode = (!we && $urandom_range(0, 9) == 0) ? 1 : 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn(adr, we, 4'($urandom_range(0, 15)), $urandom, mode);
        end

        repeat (12) @(negedge clk);
        chk("ack_q_drained", 32'(ack_q.size()), 32'h0);
        chk("stb_q_drained", 32'(stb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
